axil_wr_arbiter_2x1: RTL and testbench

//   Two-requester AXI4-Lite write-channel arbiter sharing one downstream AXI-Lite write port
//   (e.g. a single-port RAM or the control window) between the CPU master and the external loader.

---
 rtl/axil_arb_pkg.sv | 13 +
 rtl/axil_wr_arbiter_2x1_rr_arb2.sv | 19 +
 rtl/axil_wr_arbiter_2x1.sv | 176 +++++++++++++++++
 tb/tb_axil_wr_arbiter_2x1.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the AXI4-Lite write arbiter.
package axil_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/axil_wr_arbiter_2x1_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one not served last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_idx,
  output logic       gnt_any
);

  always_comb begin
    gnt_any = |req;
    gnt_idx = 1'b0;
    if (req == 2'b11) begin
      gnt_idx = ~last;
    end else if (req == 2'b10) begin
      gnt_idx = 1'b1;
    end
  end

endmodule

// File: rtl/axil_wr_arbiter_2x1.sv
// Two-slave AXI4-Lite write arbiter: round-robin, one outstanding write,
// AW/W/B forwarded to a single downstream port as an atomic transaction.
module axil_wr_arbiter_2x1
  import axil_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic [ADDR_W-1:0] s0_awaddr,
  input  logic              s0_awvalid,
  output logic              s0_awready,
  input  logic [DATA_W-1:0] s0_wdata,
  input  logic [STRB_W-1:0] s0_wstrb,
  input  logic              s0_wvalid,
  output logic              s0_wready,
  output logic [1:0]        s0_bresp,
  output logic              s0_bvalid,
  input  logic              s0_bready,

  input  logic [ADDR_W-1:0] s1_awaddr,
  input  logic              s1_awvalid,
  output logic              s1_awready,
  input  logic [DATA_W-1:0] s1_wdata,
  input  logic [STRB_W-1:0] s1_wstrb,
  input  logic              s1_wvalid,
  output logic              s1_wready,
  output logic [1:0]        s1_bresp,
  output logic              s1_bvalid,
  input  logic              s1_bready,

  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [DATA_W-1:0] m_wdata,
  output logic [STRB_W-1:0] m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,

  output logic [1:0]        dbg_state
);

  // Handshakes: a beat transfers on a cycle where valid and ready are both high;
  // valid never depends on ready, and ready only on the granted path's state.

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_q, last_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;

  logic       pick_idx;
  logic       pick_any;

  logic       sel_awvalid;
  logic       sel_wvalid;
  logic       sel_bready;
  logic       aw_hs;
  logic       w_hs;

  rr_arb2 u_rr (
    .req     ({s1_awvalid, s0_awvalid}),
    .last    (last_q),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;

    m_awaddr   = '0;
    m_awvalid  = 1'b0;
    m_wdata    = '0;
    m_wstrb    = '0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;

    s0_awready = 1'b0;
    s0_wready  = 1'b0;
    s0_bresp   = OKAY;
    s0_bvalid  = 1'b0;
    s1_awready = 1'b0;
    s1_wready  = 1'b0;
    s1_bresp   = OKAY;
    s1_bvalid  = 1'b0;

    sel_awvalid = grant_q ? s1_awvalid : s0_awvalid;
    sel_wvalid  = grant_q ? s1_wvalid  : s0_wvalid;
    sel_bready  = grant_q ? s1_bready  : s0_bready;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ADDR;
        end
      end

      ADDR: begin
        m_awaddr  = grant_q ? s1_awaddr : s0_awaddr;
        m_wdata   = grant_q ? s1_wdata  : s0_wdata;
        m_wstrb   = grant_q ? s1_wstrb  : s0_wstrb;
        m_awvalid = sel_awvalid & ~aw_done_q;
        m_wvalid  = sel_wvalid & ~w_done_q;
        if (grant_q) begin
          s1_awready = m_awready & ~aw_done_q;
          s1_wready  = m_wready & ~w_done_q;
        end else begin
          s0_awready = m_awready & ~aw_done_q;
          s0_wready  = m_wready & ~w_done_q;
        end
        aw_hs = m_awvalid & m_awready;
        w_hs  = m_wvalid & m_wready;
        // Either channel may finish first; the flags remember which one already has.
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = RESP;
        end else begin
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q | w_hs;
        end
      end

      RESP: begin
        m_bready = sel_bready;
        if (grant_q) begin
          s1_bvalid = m_bvalid;
          s1_bresp  = m_bresp;
        end else begin
          s0_bvalid = m_bvalid;
          s0_bresp  = m_bresp;
        end
        if (m_bvalid && m_bready) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axil_wr_arbiter_2x1.sv
// Directed bench for the two-slave AXI4-Lite write arbiter.
module tb_axil_wr_arbiter_2x1;
  import axil_arb_pkg::*;

  logic        clk;
  logic        resetn;
  logic [31:0] s0_awaddr, s1_awaddr, m_awaddr;
  logic        s0_awvalid, s0_awready, s1_awvalid, s1_awready;
  logic [31:0] s0_wdata, s1_wdata, m_wdata;
  logic [3:0]  s0_wstrb, s1_wstrb, m_wstrb;
  logic        s0_wvalid, s0_wready, s1_wvalid, s1_wready;
  logic [1:0]  s0_bresp, s1_bresp, m_bresp;
  logic        s0_bvalid, s0_bready, s1_bvalid, s1_bready;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [1:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;

  axil_wr_arbiter_2x1 #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .s0_awaddr(s0_awaddr), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
    .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
    .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
    .s1_awaddr(s1_awaddr), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
    .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
    .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_s(input int n, input logic [31:0] a, input logic [31:0] d);
    if (n == 0) begin
      s0_awaddr = a; s0_wdata = d; s0_wstrb = 4'hF; s0_awvalid = 1'b1; s0_wvalid = 1'b1;
    end else begin
      s1_awaddr = a; s1_wdata = d; s1_wstrb = 4'hF; s1_awvalid = 1'b1; s1_wvalid = 1'b1;
    end
  endtask

  task automatic clr_s(input int n);
    if (n == 0) begin
      s0_awvalid = 1'b0; s0_wvalid = 1'b0;
    end else begin
      s1_awvalid = 1'b0; s1_wvalid = 1'b0;
    end
  endtask

  // Completes one write with an always-ready downstream; reports who was granted.
  task automatic serve(input logic [1:0] resp, output int g, output logic [31:0] a,
                       output logic [1:0] br, output logic obv);
    int n;
    n = 0; g = -1; a = '0; br = 2'b11; obv = 1'b1;
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0;
    s0_bready = 1'b1; s1_bready = 1'b1;
    #1;
    while (dbg_state != ADDR && n < 20) begin
      cyc(); #1; n++;
    end
    vectors++;
    if (n >= 20) begin
      miscompares++;
      $display("FAIL serve_timeout: state=%0d after %0d cycles, required ADDR", dbg_state, n);
      return;
    end
    a = m_awaddr;
    g = s0_awready ? 0 : (s1_awready ? 1 : -2);
    cyc();
    if (g >= 0) clr_s(g);
    m_bvalid = 1'b1; m_bresp = resp;
    #1;
    br  = (g == 1) ? s1_bresp : s0_bresp;
    obv = (g == 1) ? s0_bvalid : s1_bvalid;
    cyc();
    m_bvalid = 1'b0; m_bresp = 2'b00;
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0; m_bresp = 2'b00;
    cyc(); cyc(); #1;
    vectors++;
    if (dbg_state !== 2'd0) begin
      miscompares++; $display("FAIL reset_state: got %0d required 0", dbg_state);
    end
    vectors++;
    if ({m_awvalid, m_wvalid, m_bready, s0_awready, s1_wready} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b required 00000",
               {m_awvalid, m_wvalid, m_bready, s0_awready, s1_wready});
    end
    resetn = 1'b1;
    m_awready = 1'b0; m_wready = 1'b0;
  endtask

  task automatic test_single_write();
    cyc();
    m_awready = 1'b1; m_wready = 1'b1; s0_bready = 1'b1;
    set_s(0, 32'h100, 32'hDEADBEEF);
    #1;
    vectors++;
    if (m_awvalid !== 1'b0) begin
      miscompares++; $display("FAIL single_idle_awvalid: got %b required 0", m_awvalid);
    end
    cyc(); #1;
    vectors++;
    if (m_awvalid !== 1'b1 || m_awaddr !== 32'h100) begin
      miscompares++;
      $display("FAIL single_aw: got valid=%b addr=%h required 1/00000100", m_awvalid, m_awaddr);
    end
    vectors++;
    if (m_wvalid !== 1'b1 || m_wdata !== 32'hDEADBEEF || m_wstrb !== 4'hF) begin
      miscompares++;
      $display("FAIL single_w: got valid=%b data=%h strb=%h required 1/deadbeef/f",
               m_wvalid, m_wdata, m_wstrb);
    end
    vectors++;
    if (s0_awready !== 1'b1 || s1_awready !== 1'b0) begin
      miscompares++;
      $display("FAIL single_awready: got s0=%b s1=%b required 1/0", s0_awready, s1_awready);
    end
    cyc();
    clr_s(0);
    m_bvalid = 1'b1; m_bresp = OKAY;
    #1;
    vectors++;
    if (s0_bvalid !== 1'b1 || m_bready !== 1'b1 || s1_bvalid !== 1'b0 || m_awvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_b: got s0_bvalid=%b m_bready=%b s1_bvalid=%b m_awvalid=%b required 1/1/0/0",
               s0_bvalid, m_bready, s1_bvalid, m_awvalid);
    end
    cyc();
    m_bvalid = 1'b0;
    #1;
    vectors++;
    if (dbg_state !== 2'd0 || s0_bvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_done: got state=%0d s0_bvalid=%b required 0/0", dbg_state, s0_bvalid);
    end
  endtask

  task automatic test_round_robin();
    int g;
    logic [31:0] a;
    logic [1:0] br;
    logic obv;
    int exp_g[4] = '{0, 1, 0, 1};
    logic [31:0] exp_a[4] = '{32'h200, 32'h300, 32'h210, 32'h310};
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 0 || k == 2) begin
        cyc();
        set_s(0, exp_a[k], 32'h11110000 + k);
        set_s(1, exp_a[k+1], 32'h22220000 + k);
      end
      serve(2'b00, g, a, br, obv);
      vectors++;
      if (g !== exp_g[k] || a !== exp_a[k]) begin
        miscompares++;
        $display("FAIL rr_order_%0d: got grant=%0d addr=%h required %0d/%h",
                 k, g, a, exp_g[k], exp_a[k]);
      end
    end
  endtask

  task automatic test_w_before_aw();
    int aw_cnt, w_cnt;
    aw_cnt = 0; w_cnt = 0;
    m_awready = 1'b0; m_wready = 1'b1; s0_bready = 1'b1;
    cyc();
    set_s(0, 32'h380, 32'hA5A5A5A5);
    cyc(); #1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) m_awready = 1'b1;
      #1;
      if (m_awvalid && m_awready) aw_cnt++;
      if (m_wvalid && m_wready) w_cnt++;
      if (k == 1) begin
        vectors++;
        if (m_wvalid !== 1'b0) begin
          miscompares++; $display("FAIL w_drop: got m_wvalid=%b required 0", m_wvalid);
        end
      end
      cyc();
    end
    #1;
    vectors++;
    if (dbg_state !== 2'd2 || aw_cnt != 1 || w_cnt != 1) begin
      miscompares++;
      $display("FAIL w_first_counts: got state=%0d aw=%0d w=%0d required 2/1/1",
               dbg_state, aw_cnt, w_cnt);
    end
    clr_s(0);
    m_bvalid = 1'b1;
    cyc();
    m_bvalid = 1'b0;
    #1;
  endtask

  task automatic test_bready_stall();
    m_awready = 1'b1; m_wready = 1'b1;
    cyc();
    set_s(0, 32'h400, 32'h44444444);
    set_s(1, 32'h500, 32'h55555555);
    cyc(); #1;
    vectors++;
    if (s1_awready !== 1'b1 || s0_awready !== 1'b0 || m_awaddr !== 32'h500) begin
      miscompares++;
      $display("FAIL stall_grant_s1: got s1_awready=%b s0_awready=%b addr=%h required 1/0/00000500",
               s1_awready, s0_awready, m_awaddr);
    end
    cyc();
    clr_s(1);
    s1_bready = 1'b0; m_bvalid = 1'b1; m_bresp = OKAY;
    #1;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (m_bready !== 1'b0 || s1_bvalid !== 1'b1 || s0_awready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold_%0d: got m_bready=%b s1_bvalid=%b s0_awready=%b required 0/1/0",
                 k, m_bready, s1_bvalid, s0_awready);
      end
      cyc(); #1;
    end
    s1_bready = 1'b1;
    #1;
    vectors++;
    if (m_bready !== 1'b1) begin
      miscompares++; $display("FAIL stall_release: got m_bready=%b required 1", m_bready);
    end
    cyc();
    m_bvalid = 1'b0;
    cyc(); #1;
    vectors++;
    if (s0_awready !== 1'b1 || m_awaddr !== 32'h400) begin
      miscompares++;
      $display("FAIL stall_then_s0: got s0_awready=%b addr=%h required 1/00000400",
               s0_awready, m_awaddr);
    end
    cyc();
    clr_s(0);
    m_bvalid = 1'b1;
    cyc();
    m_bvalid = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid_txn();
    m_awready = 1'b1; m_wready = 1'b0;
    cyc();
    set_s(0, 32'h600, 32'h66666666);
    cyc(); cyc(); #1;
    vectors++;
    if (dbg_state !== 2'd1 || m_awvalid !== 1'b0 || m_wvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_aw_done: got state=%0d awvalid=%b wvalid=%b required 1/0/1",
               dbg_state, m_awvalid, m_wvalid);
    end
    resetn = 1'b0; m_wready = 1'b1; m_bvalid = 1'b1;
    cyc(); #1;
    vectors++;
    if (dbg_state !== 2'd0 || {m_awvalid, m_wvalid, s0_awready, s0_wready, s0_bvalid, m_bready} !== 6'b0) begin
      miscompares++;
      $display("FAIL midrst_cleared: got state=%0d sigs=%b required 0/000000", dbg_state,
               {m_awvalid, m_wvalid, s0_awready, s0_wready, s0_bvalid, m_bready});
    end
    resetn = 1'b1; m_bvalid = 1'b0;
    set_s(1, 32'h700, 32'h77777777);
    cyc(); #1;
    vectors++;
    if (s0_awready !== 1'b1 || s1_awready !== 1'b0 || m_awaddr !== 32'h600) begin
      miscompares++;
      $display("FAIL midrst_regrant: got s0_awready=%b s1_awready=%b addr=%h required 1/0/00000600",
               s0_awready, s1_awready, m_awaddr);
    end
    cyc();
    clr_s(0);
    s0_bready = 1'b1; m_bvalid = 1'b1;
    cyc();
    m_bvalid = 1'b0;
    #1;
  endtask

  task automatic test_slverr();
    int g;
    logic [31:0] a;
    logic [1:0] br;
    logic obv;
    serve(SLVERR, g, a, br, obv);
    vectors++;
    if (g !== 1 || a !== 32'h700) begin
      miscompares++;
      $display("FAIL slverr_grant: got grant=%0d addr=%h required 1/00000700", g, a);
    end
    vectors++;
    if (br !== 2'b10 || obv !== 1'b0) begin
      miscompares++;
      $display("FAIL slverr_resp: got bresp=%b other_bvalid=%b required 10/0", br, obv);
    end
  endtask

  initial begin
    resetn = 1'b0;
    s0_awaddr = '0; s0_awvalid = 1'b0; s0_wdata = '0; s0_wstrb = '0; s0_wvalid = 1'b0; s0_bready = 1'b0;
    s1_awaddr = '0; s1_awvalid = 1'b0; s1_wdata = '0; s1_wstrb = '0; s1_wvalid = 1'b0; s1_bready = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_bresp = 2'b00; m_bvalid = 1'b0;

    test_reset();
    test_single_write();
    test_round_robin();
    test_w_before_aw();
    test_bready_stall();
    test_reset_mid_txn();
    test_slverr();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
